population_eval_scheduler: RTL and testbench

POPULATION_EVAL_SCHEDULER -- requirements
Module: population_eval_scheduler

---
 rtl/population_eval_scheduler_pkg.sv | 38 +++
 rtl/population_eval_scheduler_fitness_adder.sv | 40 ++++
 rtl/population_eval_scheduler.sv | 171 +++++++++++++++++
 tb/tb_population_eval_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/population_eval_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// population_eval_scheduler_pkg : state encoding, datapath widths, error summing
// Revision 1.0
// ============================================================================
package population_eval_scheduler_pkg;

   localparam int c_ERR_CNT = 8;
   localparam int c_ERR_W   = 32;
   localparam int c_FIT_W   = 35;
   localparam int c_IDX_W   = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_ACK    = 3'd4,
      S_NEXT   = 3'd5,
      S_FINISH = 3'd6
   } state_e;

   typedef logic [c_FIT_W-1:0] fit_t;

   localparam fit_t c_FIT_MAX = '1;

   // 8 x 32-bit terms fit in 35 bits, so the running sum can never wrap
   function automatic fit_t sum_errors(input logic [c_ERR_CNT-1:0][c_ERR_W-1:0] e);
      fit_t s;
      s = '0;
      for (int i = 0; i < c_ERR_CNT; i++) begin
         s = s + fit_t'(e[i]);
      end
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/population_eval_scheduler_fitness_adder.sv
`default_nettype none
// ============================================================================
// population_eval_scheduler_fitness_adder : registered 8x32 -> 35-bit fitness
// Revision 1.0
// ============================================================================
module population_eval_scheduler_fitness_adder
   import population_eval_scheduler_pkg::*;
(
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              capture_i,
   input  logic                              force_max_i,
   input  logic [c_ERR_CNT-1:0][c_ERR_W-1:0] err_sums_i,
   output logic [c_FIT_W-1:0]                fitness_o
);

   fit_t fitness_q;
   fit_t fitness_d;

   always_comb begin
      fitness_d = fitness_q;
      if (capture_i) begin
         fitness_d = sum_errors(err_sums_i);
      end else if (force_max_i) begin
         fitness_d = c_FIT_MAX;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fitness_q <= '0;
      end else begin
         fitness_q <= fitness_d;
      end
   end

   assign fitness_o = fitness_q;

endmodule
`default_nettype wire

// File: rtl/population_eval_scheduler.sv
`default_nettype none
// ============================================================================
// population_eval_scheduler : sequences a population through an external
// evaluator, writes each fitness and tracks the best chromosome of the run.
// Revision 1.0
// ============================================================================
module population_eval_scheduler
   import population_eval_scheduler_pkg::*;
#(
   parameter int POP_SIZE    = 16,
   parameter int LOAD_CYCLES = 2,
   parameter int TIMEOUT     = 65535
) (
   input  logic                              iClock,
   input  logic                              iReset,
   input  logic                              iStart,
   output logic                              oBusy,
   output logic                              oDone,
   output logic [c_IDX_W-1:0]                oChromIndex,
   output logic                              oProcStart,
   input  logic                              iProcReady,
   input  logic                              iProcDone,
   output logic                              oProcDoneFeedback,
   input  logic [c_ERR_CNT-1:0][c_ERR_W-1:0] iErrorSums,
   output logic                              oFitWrEn,
   output logic [c_IDX_W-1:0]                oFitWrAddr,
   output logic [c_FIT_W-1:0]                oFitWrData,
   output logic [c_IDX_W-1:0]                oBestIndex,
   output logic [c_FIT_W-1:0]                oBestFitness,
   output logic                              oTimeout
);

   localparam int c_LD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
   localparam int c_TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e               state_q, state_d;
   logic [c_IDX_W-1:0]   chrom_q, chrom_d;
   logic [c_LD_W-1:0]    ld_cnt_q, ld_cnt_d;
   logic [c_TO_W-1:0]    to_cnt_q, to_cnt_d;
   logic                 wr_en_q, wr_en_d;
   logic                 timeout_q, timeout_d;
   logic [c_IDX_W-1:0]   best_idx_q, best_idx_d;
   fit_t                 best_fit_q, best_fit_d;
   logic                 capture;
   logic                 force_max;
   fit_t                 fitness;

   population_eval_scheduler_fitness_adder u_fitness_adder (
      .clk_i       (iClock),
      .rst_i       (iReset),
      .capture_i   (capture),
      .force_max_i (force_max),
      .err_sums_i  (iErrorSums),
      .fitness_o   (fitness)
   );

   always_comb begin
      state_d    = state_q;
      chrom_d    = chrom_q;
      ld_cnt_d   = ld_cnt_q;
      to_cnt_d   = to_cnt_q;
      timeout_d  = timeout_q;
      best_idx_d = best_idx_q;
      best_fit_d = best_fit_q;
      capture    = 1'b0;
      force_max  = 1'b0;

      // Strict compare: an equal fitness later in the run keeps the lower index
      if (wr_en_q && (fitness < best_fit_q)) begin
         best_fit_d = fitness;
         best_idx_d = chrom_q;
      end

      case (state_q)
         S_IDLE: begin
            if (iStart) begin
               state_d    = S_LOAD;
               chrom_d    = '0;
               ld_cnt_d   = '0;
               timeout_d  = 1'b0;
               best_idx_d = '0;
               best_fit_d = c_FIT_MAX;
            end
         end
         S_LOAD: begin
            if (ld_cnt_q == c_LD_W'(LOAD_CYCLES - 1)) begin
               state_d = S_START;
            end else begin
               ld_cnt_d = ld_cnt_q + 1'b1;
            end
         end
         S_START: begin
            if (!iProcReady) begin
               state_d  = S_WAIT;
               to_cnt_d = '0;
            end
         end
         S_WAIT: begin
            // A done arriving on the timeout cycle still delivers real sums
            if (iProcDone) begin
               capture = 1'b1;
               state_d = S_ACK;
            end else if (to_cnt_q == c_TO_W'(TIMEOUT - 1)) begin
               force_max = 1'b1;
               timeout_d = 1'b1;
               state_d   = S_ACK;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_ACK: begin
            if (iProcReady) begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (chrom_q == c_IDX_W'(POP_SIZE - 1)) begin
               state_d = S_FINISH;
            end else begin
               chrom_d  = chrom_q + 1'b1;
               ld_cnt_d = '0;
               state_d  = S_LOAD;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      wr_en_d = capture | force_max;
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q    <= S_IDLE;
         chrom_q    <= '0;
         ld_cnt_q   <= '0;
         to_cnt_q   <= '0;
         wr_en_q    <= 1'b0;
         timeout_q  <= 1'b0;
         best_idx_q <= '0;
         best_fit_q <= c_FIT_MAX;
      end else begin
         state_q    <= state_d;
         chrom_q    <= chrom_d;
         ld_cnt_q   <= ld_cnt_d;
         to_cnt_q   <= to_cnt_d;
         wr_en_q    <= wr_en_d;
         timeout_q  <= timeout_d;
         best_idx_q <= best_idx_d;
         best_fit_q <= best_fit_d;
      end
   end

   assign oBusy             = (state_q != S_IDLE);
   assign oDone             = (state_q == S_FINISH);
   assign oProcStart        = (state_q == S_START);
   assign oProcDoneFeedback = (state_q == S_ACK);
   assign oChromIndex       = chrom_q;
   assign oFitWrEn          = wr_en_q;
   assign oFitWrAddr        = chrom_q;
   assign oFitWrData        = fitness;
   assign oBestIndex        = best_idx_q;
   assign oBestFitness      = best_fit_q;
   assign oTimeout          = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_population_eval_scheduler.sv
`default_nettype none
// ============================================================================
// tb_population_eval_scheduler : randomized self-checking bench with a
// processor responder and a behavioural fitness/best-tracking model.
// Revision 1.0
// ============================================================================
module tb_population_eval_scheduler;

   localparam int POP = 4;
   localparam int TO  = 20;

   typedef struct {
      logic [7:0]  addr;
      logic [34:0] data;
   } wr_t;

   logic             iClock, iReset, iStart;
   logic             oBusy, oDone, oProcStart, oProcDoneFeedback;
   logic             iProcReady, iProcDone;
   logic [7:0]       oChromIndex, oFitWrAddr, oBestIndex;
   logic [7:0][31:0] iErrorSums;
   logic             oFitWrEn, oTimeout;
   logic [34:0]      oFitWrData, oBestFitness;

   int          total = 0;
   int          bad   = 0;
   int          delay_tab [POP];
   bit          never_tab [POP];
   logic [31:0] sums_tab  [POP][8];
   wr_t         wq [$];
   int          done_total = 0;
   bit          p_busy = 0;
   int          p_cnt  = 0;
   int          p_cur  = 0;

   population_eval_scheduler #(
      .POP_SIZE    (POP),
      .LOAD_CYCLES (2),
      .TIMEOUT     (TO)
   ) dut (
      .iClock            (iClock),
      .iReset            (iReset),
      .iStart            (iStart),
      .oBusy             (oBusy),
      .oDone             (oDone),
      .oChromIndex       (oChromIndex),
      .oProcStart        (oProcStart),
      .iProcReady        (iProcReady),
      .iProcDone         (iProcDone),
      .oProcDoneFeedback (oProcDoneFeedback),
      .iErrorSums        (iErrorSums),
      .oFitWrEn          (oFitWrEn),
      .oFitWrAddr        (oFitWrAddr),
      .oFitWrData        (oFitWrData),
      .oBestIndex        (oBestIndex),
      .oBestFitness      (oBestFitness),
      .oTimeout          (oTimeout)
   );

   initial begin
      iClock = 1'b0;
      forever #5 iClock = ~iClock;
   end

   // Processor responder: accepts a start, asserts done after delay_tab cycles
   // unless marked never, returns to ready on feedback or when the run aborts.
   always @(negedge iClock) begin
      if (iReset || !oBusy || oProcDoneFeedback) begin
         iProcReady = 1'b1;
         iProcDone  = 1'b0;
         p_busy     = 1'b0;
      end else if (!p_busy && oProcStart && iProcReady) begin
         iProcReady = 1'b0;
         p_busy     = 1'b1;
         p_cnt      = 0;
         p_cur      = int'(oChromIndex) % POP;
      end else if (p_busy && !iProcDone) begin
         p_cnt++;
         if (!never_tab[p_cur] && p_cnt == delay_tab[p_cur]) begin
            iProcDone = 1'b1;
            for (int i = 0; i < 8; i++) iErrorSums[i] = sums_tab[p_cur][i];
         end
      end
      if (!iProcDone) begin
         for (int i = 0; i < 8; i++) iErrorSums[i] = $urandom;
      end
   end

   always @(negedge iClock) begin
      if (oFitWrEn) wq.push_back('{addr: oFitWrAddr, data: oFitWrData});
      if (oDone) done_total++;
   end

   // Reference: a chromosome times out when it never finishes or finishes
   // later than the TO-th waiting cycle; otherwise fitness is the plain sum.
   function automatic logic [34:0] model_fit(input int c);
      longint s;
      if (never_tab[c] || delay_tab[c] > TO) return {35{1'b1}};
      s = 0;
      for (int i = 0; i < 8; i++) s += longint'(sums_tab[c][i]);
      return 35'(s);
   endfunction

   function automatic bit model_timeout();
      for (int c = 0; c < POP; c++)
         if (never_tab[c] || delay_tab[c] > TO) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_best(output logic [7:0] idx, output logic [34:0] fit);
      idx = 8'd0;
      fit = {35{1'b1}};
      for (int c = 0; c < POP; c++) begin
         if (model_fit(c) < fit) begin
            fit = model_fit(c);
            idx = 8'(c);
         end
      end
   endtask

   function automatic void set_target(input int c, input int target);
      int rem;
      rem = target;
      for (int i = 0; i < 7; i++) begin
         sums_tab[c][i] = 32'($urandom_range(0, rem));
         rem -= int'(sums_tab[c][i]);
      end
      sums_tab[c][7] = 32'(rem);
   endfunction

   function automatic void randomize_chrom(input int c);
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) begin
         case (mode)
            0:       sums_tab[c][i] = 32'($urandom_range(0, 3));
            1:       sums_tab[c][i] = $urandom;
            default: sums_tab[c][i] = 32'($urandom_range(0, 1000));
         endcase
      end
   endfunction

   task automatic run_pop(output bit ok);
      int start_done;
      int n;
      start_done = done_total;
      @(negedge iClock);
      iStart = 1'b1;
      @(negedge iClock);
      iStart = 1'b0;
      n = 0;
      while (done_total == start_done && n < 3000) begin
         @(negedge iClock);
         n++;
      end
      ok = (done_total != start_done);
      repeat (3) @(negedge iClock);
   endtask

   task automatic test_reset();
      iReset = 1'b1;
      iStart = 1'b0;
      repeat (3) @(negedge iClock);
      total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", oBusy); end
      total++; if (oDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", oDone); end
      total++; if (oProcStart !== 1'b0 || oProcDoneFeedback !== 1'b0) begin bad++; $display("FAIL reset_handshake got=%b%b exp=00", oProcStart, oProcDoneFeedback); end
      total++; if (oFitWrEn !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b exp=0", oFitWrEn); end
      total++; if (oChromIndex !== 8'd0 || oFitWrAddr !== 8'd0) begin bad++; $display("FAIL reset_index got=%0d/%0d exp=0/0", oChromIndex, oFitWrAddr); end
      total++; if (oFitWrData !== 35'd0) begin bad++; $display("FAIL reset_wrdata got=%h exp=0", oFitWrData); end
      total++; if (oBestFitness !== {35{1'b1}}) begin bad++; $display("FAIL reset_bestfit got=%h exp=7ffffffff", oBestFitness); end
      total++; if (oBestIndex !== 8'd0 || oTimeout !== 1'b0) begin bad++; $display("FAIL reset_best_idx_to got=%0d/%b exp=0/0", oBestIndex, oTimeout); end
      iReset = 1'b0;
      @(negedge iClock);
   endtask

   task automatic test_directed();
      int targets [POP] = '{40, 10, 10, 25};
      int base;
      bit ok;
      for (int c = 0; c < POP; c++) begin
         delay_tab[c] = 10; never_tab[c] = 0; set_target(c, targets[c]);
      end
      base = wq.size();
      run_pop(ok);
      total++; if (!ok) begin bad++; $display("FAIL directed_run_finish got=no_done exp=done"); end
      total++; if (wq.size() - base != POP) begin bad++; $display("FAIL directed_wr_count got=%0d exp=%0d", wq.size() - base, POP); end
      for (int c = 0; c < POP && base + c < wq.size(); c++) begin
         total++;
         if (wq[base+c].addr !== 8'(c) || wq[base+c].data !== 35'(targets[c])) begin
            bad++; $display("FAIL directed_wr%0d got=%0d:%0d exp=%0d:%0d", c, wq[base+c].addr, wq[base+c].data, c, targets[c]);
         end
      end
      total++; if (oBestIndex !== 8'd1 || oBestFitness !== 35'd10) begin bad++; $display("FAIL directed_best got=%0d/%0d exp=1/10", oBestIndex, oBestFitness); end
      total++; if (oTimeout !== 1'b0 || oBusy !== 1'b0) begin bad++; $display("FAIL directed_idle got=to%b busy%b exp=0/0", oTimeout, oBusy); end
   endtask

   task automatic test_overflow();
      int base;
      bit ok;
      logic [7:0]  eidx;
      logic [34:0] efit;
      for (int c = 0; c < POP; c++) begin
         delay_tab[c] = int'($urandom_range(1, 15)); never_tab[c] = 0; randomize_chrom(c);
      end
      for (int i = 0; i < 8; i++) sums_tab[0][i] = 32'hFFFF_FFFF;
      base = wq.size();
      run_pop(ok);
      model_best(eidx, efit);
      total++; if (!ok || wq.size() - base != POP) begin bad++; $display("FAIL overflow_run got=%0d writes exp=%0d", wq.size() - base, POP); end
      if (wq.size() > base) begin
         total++; if (wq[base].data !== 35'h7_FFFF_FFF8) begin bad++; $display("FAIL overflow_sum got=%h exp=7fffffff8", wq[base].data); end
      end
      total++; if (oBestIndex !== eidx || oBestFitness !== efit) begin bad++; $display("FAIL overflow_best got=%0d/%h exp=%0d/%h", oBestIndex, oBestFitness, eidx, efit); end
   endtask

   task automatic test_timeout();
      int base;
      bit ok;
      for (int c = 0; c < POP; c++) begin
         delay_tab[c] = int'($urandom_range(1, TO - 1)); never_tab[c] = 0; randomize_chrom(c);
      end
      never_tab[2] = 1;
      base = wq.size();
      run_pop(ok);
      total++; if (!ok || wq.size() - base != POP) begin bad++; $display("FAIL timeout_run got=%0d writes exp=%0d", wq.size() - base, POP); end
      for (int c = 0; c < POP && base + c < wq.size(); c++) begin
         total++;
         if (wq[base+c].addr !== 8'(c) || wq[base+c].data !== model_fit(c)) begin
            bad++; $display("FAIL timeout_wr%0d got=%0d:%h exp=%0d:%h", c, wq[base+c].addr, wq[base+c].data, c, model_fit(c));
         end
      end
      total++; if (oTimeout !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b exp=1", oTimeout); end
      never_tab[2] = 0;
   endtask

   task automatic test_coincide();
      int base;
      bit ok;
      for (int c = 0; c < POP; c++) begin
         delay_tab[c] = 5; never_tab[c] = 0; randomize_chrom(c);
      end
      delay_tab[1] = TO;
      base = wq.size();
      run_pop(ok);
      total++; if (!ok || wq.size() - base != POP) begin bad++; $display("FAIL coincide_run got=%0d writes exp=%0d", wq.size() - base, POP); end
      if (wq.size() > base + 1) begin
         total++; if (wq[base+1].data !== model_fit(1)) begin bad++; $display("FAIL coincide_data got=%h exp=%h", wq[base+1].data, model_fit(1)); end
      end
      total++; if (oTimeout !== 1'b0) begin bad++; $display("FAIL coincide_flag got=%b exp=0", oTimeout); end
   endtask

   task automatic test_ignore_start();
      int base, dbase, post;
      bit seen;
      for (int c = 0; c < POP; c++) begin
         delay_tab[c] = 10; never_tab[c] = 0; randomize_chrom(c);
      end
      base  = wq.size();
      dbase = done_total;
      seen  = 0;
      post  = 0;
      @(negedge iClock);
      iStart = 1'b1;
      for (int k = 0; k < 3000 && post < 30; k++) begin
         @(negedge iClock);
         iStart = 1'b0;
         if (p_busy && p_cnt == 3) iStart = 1'b1;
         if (oDone) begin iStart = 1'b1; seen = 1; end
         else if (seen) post++;
      end
      iStart = 1'b0;
      total++; if (wq.size() - base != POP) begin bad++; $display("FAIL ignore_wr_count got=%0d exp=%0d", wq.size() - base, POP); end
      total++; if (done_total - dbase != 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", done_total - dbase); end
      total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL ignore_busy got=%b exp=0", oBusy); end
   endtask

   task automatic test_reset_mid_run();
      int base, dbase, n;
      for (int c = 0; c < POP; c++) begin
         delay_tab[c] = 10; never_tab[c] = 0; randomize_chrom(c);
      end
      base  = wq.size();
      dbase = done_total;
      @(negedge iClock);
      iStart = 1'b1;
      @(negedge iClock);
      iStart = 1'b0;
      n = 0;
      while (!(oChromIndex == 8'd1 && p_busy && p_cnt >= 3) && n < 500) begin
         @(negedge iClock);
         n++;
      end
      total++; if (n >= 500) begin bad++; $display("FAIL midreset_reach_wait got=timeout exp=chrom1_wait"); end
      iReset = 1'b1;
      @(negedge iClock);
      total++; if (oBusy !== 1'b0 || oProcStart !== 1'b0 || oProcDoneFeedback !== 1'b0) begin bad++; $display("FAIL midreset_idle got=%b%b%b exp=000", oBusy, oProcStart, oProcDoneFeedback); end
      iReset = 1'b0;
      repeat (40) @(negedge iClock);
      total++; if (wq.size() - base != 1) begin bad++; $display("FAIL midreset_writes got=%0d exp=1", wq.size() - base); end
      total++; if (done_total != dbase || oBusy !== 1'b0) begin bad++; $display("FAIL midreset_done got=%0d busy=%b exp=0/0", done_total - dbase, oBusy); end
   endtask

   task automatic test_random();
      int base;
      bit ok;
      logic [7:0]  eidx;
      logic [34:0] efit;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < POP; c++) begin
            delay_tab[c] = int'($urandom_range(1, TO + 4));
            never_tab[c] = ($urandom_range(0, 9) == 0);
            randomize_chrom(c);
         end
         base = wq.size();
         run_pop(ok);
         model_best(eidx, efit);
         total++; if (!ok || wq.size() - base != POP) begin bad++; $display("FAIL rand%0d_run got=%0d writes exp=%0d", r, wq.size() - base, POP); end
         for (int c = 0; c < POP && base + c < wq.size(); c++) begin
            total++;
            if (wq[base+c].addr !== 8'(c) || wq[base+c].data !== model_fit(c)) begin
               bad++; $display("FAIL rand%0d_wr%0d got=%0d:%h exp=%0d:%h", r, c, wq[base+c].addr, wq[base+c].data, c, model_fit(c));
            end
         end
         total++; if (oBestIndex !== eidx || oBestFitness !== efit) begin bad++; $display("FAIL rand%0d_best got=%0d/%h exp=%0d/%h", r, oBestIndex, oBestFitness, eidx, efit); end
         total++; if (oTimeout !== model_timeout()) begin bad++; $display("FAIL rand%0d_timeout got=%b exp=%b", r, oTimeout, model_timeout()); end
      end
   endtask

   initial begin
      iReset = 1'b1;
      iStart = 1'b0;
      for (int c = 0; c < POP; c++) begin
         delay_tab[c] = 10; never_tab[c] = 0;
         for (int i = 0; i < 8; i++) sums_tab[c][i] = '0;
      end
      test_reset();
      test_directed();
      test_overflow();
      test_timeout();
      test_coincide();
      test_ignore_start();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
